dot_product_mac_4bit: RTL and testbench

//  Downstream consumer of the 4-bit Wallace tree multiplier. Accepts a stream of 4-bit operand

---
 rtl/dot_product_mac_4bit.sv | 174 +++++++++++++++++
 tb/tb_dot_product_mac_4bit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dot_product_mac_4bit.sv
// Streaming dot-product engine: 4-bit operand pairs in over valid/ready, a Wallace tree
// multiplier per term, and a LEN-term sum held on a valid/ready output until consumed.

module wallace_tree_multiplier_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);
    // Returned as {carry, sum}.
    function automatic logic [1:0] ha(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
        return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
    endfunction

    // pp[i][j] carries weight i+j.
    logic [3:0] pp [4];
    logic [1:0] s1_w1, s1_w2, s1_w3, s1_w4;
    logic [1:0] s2_w2, s2_w3, s2_w4, s2_w5;
    logic [7:0] row_x, row_y;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pp[i] = a & {4{b[i]}};
        end
    end

    assign s1_w1 = ha(pp[0][1], pp[1][0]);
    assign s1_w2 = fa(pp[0][2], pp[1][1], pp[2][0]);
    assign s1_w3 = fa(pp[0][3], pp[1][2], pp[2][1]);
    assign s1_w4 = ha(pp[1][3], pp[2][2]);

    // Second layer leaves at most two bits per column for the final carry-propagate add.
    assign s2_w2 = ha(s1_w1[1], s1_w2[0]);
    assign s2_w3 = fa(s1_w2[1], s1_w3[0], pp[3][0]);
    assign s2_w4 = fa(s1_w3[1], s1_w4[0], pp[3][1]);
    assign s2_w5 = fa(s1_w4[1], pp[2][3], pp[3][2]);

    assign row_x = {1'b0, pp[3][3], s2_w5[0], s2_w4[0], s2_w3[0], s2_w2[0], s1_w1[0], pp[0][0]};
    assign row_y = {1'b0, s2_w5[1], s2_w4[1], s2_w3[1], s2_w2[1], 3'b000};
    assign p     = row_x + row_y;
endmodule

module dot_product_mac_4bit #(
    parameter int LEN   = 4,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy
);
    localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;

    typedef enum logic [1:0] {
        ST_ACCUM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Handshakes: a transfer happens at a rising edge where valid && ready are both high.
    // in_ready depends only on state (and rst); out_valid only on state.
    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic             s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
    logic [7:0]       s2_prod_q, s2_prod_d;
    logic             s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       mult_p;
    logic             accept;
    logic             last_term;

    wallace_tree_multiplier_4bit u_mult (
        .a (s1_a_q),
        .b (s1_b_q),
        .p (mult_p)
    );

    assign in_ready  = (state_q == ST_ACCUM) && !rst;
    assign accept    = in_valid && in_ready && !clr;
    assign last_term = (count_q == CNT_W'(LEN - 1));
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = acc_q;
    assign busy      = !((state_q == ST_ACCUM) && (count_q == '0) && !s1_valid_q && !s2_valid_q);

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_valid_d = accept;
        s1_last_d  = accept && last_term;
        s2_prod_d  = s2_prod_q;
        s2_valid_d = s1_valid_q;
        s2_last_d  = s1_valid_q && s1_last_q;
        acc_d      = acc_q;

        if (accept) begin
            s1_a_d = in_a;
            s1_b_d = in_b;
        end
        if (s1_valid_q) begin
            s2_prod_d = mult_p;
        end
        // Bubbles leave acc untouched because only valid products are added.
        if (s2_valid_q) begin
            acc_d = acc_q + ACC_W'(s2_prod_q);
        end

        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    if (last_term) begin
                        count_d = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (s2_valid_q && s2_last_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    acc_d   = '0;
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // clr flushes everything rst does, so the two share one path.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_q    <= ST_ACCUM;
            count_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s2_prod_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s2_prod_q  <= s2_prod_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            acc_q      <= acc_d;
        end
    end
endmodule

// File: tb/tb_dot_product_mac_4bit.sv
// Bench for dot_product_mac_4bit: directed scenarios plus randomized vectors, with a
// term-list reference model feeding an expected-result queue drained by a monitor.

module tb_dot_product_mac_4bit;
    localparam int LEN   = 4;
    localparam int ACC_W = 12;

    logic             clk = 1'b0;
    logic             rst, clr, in_valid, in_ready, out_valid, out_ready, busy;
    logic [3:0]       in_a, in_b;
    logic [ACC_W-1:0] out_data;

    int total = 0;
    int bad   = 0;

    logic [ACC_W-1:0] exp_q[$];
    int               term_cnt  = 0;
    int               partial   = 0;
    int               pushed    = 0;
    int               discarded = 0;
    int               results   = 0;
    logic             held_valid = 1'b0;
    logic [ACC_W-1:0] held_data;
    bit               rand_ready = 1'b0;

    dot_product_mac_4bit #(.LEN(LEN), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Clock and random downstream readiness.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a term counts when in_valid && in_ready with no rst/clr; every
    // LEN terms produce one expected sum. rst/clr throw away partial and pending sums.
    always @(negedge clk) begin
        if (!rst && !clr) begin
            if (term_cnt != 0 || exp_q.size() != 0) check("busy_active", busy, 1);
            if (exp_q.size() != 0) check("in_ready_low_while_pending", in_ready, 0);
        end
        if (rst || clr) begin
            discarded += exp_q.size();
            exp_q.delete();
            term_cnt = 0;
            partial  = 0;
        end else if (in_valid && in_ready) begin
            partial += int'(in_a) * int'(in_b);
            term_cnt++;
            if (term_cnt == LEN) begin
                exp_q.push_back(ACC_W'(partial));
                pushed++;
                term_cnt = 0;
                partial  = 0;
            end
        end
    end

    // Monitor: compares every presented result and pops on the handshake.
    always @(negedge clk) begin
        if (rst) begin
            held_valid = 1'b0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) check("unexpected_result", out_valid, 0);
            else check("result_data", out_data, exp_q[0]);
            if (held_valid) check("held_stable", out_data, held_data);
            if (out_ready && !clr) begin
                if (exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    results++;
                end
                held_valid = 1'b0;
            end else begin
                held_valid = 1'b1;
                held_data  = out_data;
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    // Driver tasks; all drive at 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b);
        bit took = 1'b0;
        int n    = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        while (!took && n < 200) begin
            took = in_ready;
            tick();
            n++;
        end
        if (!took) check("send_timeout", took, 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        if (!out_valid) check("wait_valid_timeout", out_valid, 1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after_handshake", in_ready, 1);
        check("out_valid_after_handshake", out_valid, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        tick();
        tick();
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_release", in_ready, 1);
        tick();

        // Basic vector and latency.
        send(1, 1); send(2, 2); send(3, 3); send(15, 15);
        check("in_ready_after_last", in_ready, 0);
        wait_valid(n);
        check("latency_edges", n, 2);
        check("basic_data", out_data, 239);
        tick();
        tick();
        take();

        // Maximum products, back-to-back with out_ready held high.
        out_ready = 1'b1;
        repeat (3) begin
            repeat (4) send(15, 15);
            wait_valid(n);
            check("max_data", out_data, 900);
            tick();
            check("max_in_ready_next", in_ready, 1);
            check("max_out_valid_next", out_valid, 0);
        end
        out_ready = 1'b0;

        // Bubbles, then backpressure with ignored in_valid pulses.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) send(2, 3);
            else idle(1);
        end
        wait_valid(n);
        check("bubble_data", out_data, 24);
        in_a = 4'd5;
        in_b = 4'd5;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            tick();
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 24);
        end
        in_valid = 1'b0;
        take();
        repeat (4) send(1, 1);
        wait_valid(n);
        check("after_bp_data", out_data, 4);
        take();

        // clr mid-vector drops the partial sum and the term presented with it.
        send(7, 7); send(7, 7);
        in_valid = 1'b1; in_a = 4'd9; in_b = 4'd9; clr = 1'b1;
        tick();
        clr = 1'b0; in_valid = 1'b0;
        check("clr_busy", busy, 0);
        repeat (4) send(2, 3);
        wait_valid(n);
        check("clr_data", out_data, 24);
        take();

        // clr while the result is held.
        repeat (4) send(3, 3);
        wait_valid(n);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_done_out_valid", out_valid, 0);
        check("clr_done_out_data", out_data, 0);
        repeat (4) send(1, 3);
        wait_valid(n);
        check("post_clr_data", out_data, 12);
        take();

        // rst one cycle after the last accept, then rst while holding a result.
        repeat (4) send(5, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_partial_result", out_valid, 0);
        end
        repeat (4) send(1, 2);
        wait_valid(n);
        check("post_rst_data", out_data, 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_done_out_valid", out_valid, 0);
        check("rst_done_out_data", out_data, 0);

        // Randomized vectors with random gaps and random out_ready.
        rand_ready = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            for (int t = 0; t < LEN; t++) begin
                idle($urandom_range(0, 2));
                send(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
        end
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        rand_ready = 1'b0;
        tick();
        out_ready = 1'b0;
        check("queue_drained", exp_q.size(), 0);
        check("result_count", results, pushed - discarded);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
